keypad_scan_fifo: RTL and testbench
===================================

// Module: keypad_scan_fifo
// PURPOSE
//  Parametrised ROWS x COLS matrix-keypad scanner with a debounced press/release FSM
//  and a keycode FIFO with a valid/ready output. Replaces fixed 4x4 scan/debounce glue.
//  Downstream consumers (display shifters, command decoders) pop one code per press.
// PARAMETERS
//  ROWS          4    number of driven rows (>=2)
//  COLS          4    number of sensed columns (>=2)
//  SCAN_DIV      480  clk cycles each row is driven during scan (>=4)
//  DB_CYCLES     600  consecutive stable samples required to accept press or release
//  FIFO_DEPTH    4    keycode entries (power of 2, >=2)
//  REPEAT_DELAY  3000000  clk cycles held before first auto-repeat (KEYPAD_REPEAT_EN only)
//  REPEAT_PERIOD 600000   clk cycles between further repeats (KEYPAD_REPEAT_EN only)
// PORTS
//  clk          in   1            system clock
//  rstn         in   1            asynchronous active-low reset
//  col_i        in   COLS         raw column inputs, active-high, asynchronous
//  row_o        out  ROWS         one-hot active-high row drive
//  key_o        out  KW           FIFO head keycode, KW=$clog2(ROWS*COLS), code=row*COLS+col
//  key_valid_o  out  1            FIFO non-empty
//  key_ready_i  in   1            consumer accepts key_o when key_valid_o&&key_ready_i
//  held_o       out  1            a key is accepted and currently held
//  overflow_o   out  1            1-cycle pulse: accepted press dropped, FIFO full
// BEHAVIOUR
//  Reset (async assert, sync deassert internally): row_o=1 (row 0), key_o=0,
//   key_valid_o=0, held_o=0, overflow_o=0, FIFO empty, FSM=SCAN, all counters 0.
//  col_i passes a 2-flop synchroniser; decisions use synchronised cols only.
//  FSM states: SCAN, DB_PRESS, HELD, DB_RELEASE.
//  SCAN: row_o rotates row0..ROWS-1..row0, advancing every SCAN_DIV cycles. On the last
//   dwell cycle: exactly one col high -> latch row/col, FSM->DB_PRESS, row frozen.
//   Zero or >=2 cols high (ghost/chord) -> ignored, scan continues.
//  DB_PRESS: counter increments each cycle latched col high; any low -> SCAN (counter 0).
//   Counter reaches DB_CYCLES -> push code, FSM->HELD, held_o=1 next cycle.
//  HELD: row frozen; other keys ignored (first key wins). Latched col low -> DB_RELEASE.
//  DB_RELEASE: DB_CYCLES consecutive lows -> SCAN, held_o=0, scan resumes at next row;
//   any high -> back to HELD, counter 0. No push on release.
//  FIFO: show-ahead; key_o/key_valid_o registered, push visible next cycle.
//   Pop and push same cycle: both occur, including when full. Push when full without pop:
//   code dropped, overflow_o pulses, contents unchanged. Pop when empty: no effect.
//   Pointers wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1.
//  Reset mid-press or mid-debounce: discards latched key and FIFO contents; no push.
// CONFIGURATION
//  KEYPAD_REPEAT_EN defined: in HELD, after REPEAT_DELAY cycles push the held code again,
//   then every REPEAT_PERIOD cycles until leaving HELD; DB_RELEASE pauses the repeat timer,
//   return to HELD resumes it. Repeat pushes obey the same full/overflow rules.
//  Undefined: exactly one push per accepted press; repeat timer logic absent.
// STRUCTURE
//  keypad_pkg: scan_state_t enum, keycode width function kw(rows,cols), code type.
//  Sub-module key_fifo (parametrised depth/width, valid/ready pop, push/full/overflow).
//  Scanner, synchroniser, debounce counter and FSM stay in this module.
// TESTING  (4x4, SCAN_DIV=8, DB_CYCLES=16, FIFO_DEPTH=4 for sim)
//  Press row2/col1 clean for 40 cycles, ready=1 -> one pop, key_o=9; held_o 1 then 0 on release.
//  Bounce col1 low every 5 cycles for 60 cycles, then stable -> exactly one code 9 pushed.
//  Rows 1 col0 and col3 high together -> no push, row_o keeps rotating.
//  ready=0, five distinct presses -> codes in order, 5th press overflow_o pulses once.
//  Full FIFO, ready=1 on push cycle -> no overflow, count stays 4, order preserved.
//  rstn low during DB_PRESS -> row_o=0001, key_valid_o=0 immediately; no stale push after.
//  KEYPAD_REPEAT_EN, REPEAT_DELAY=50, REPEAT_PERIOD=20, hold 100 cycles -> 1+1+2 = 4 pushes.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix-keypad scanner and its keycode FIFO.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } scan_state_t;

  function automatic int kw(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  localparam int KW_DEFAULT = kw(4, 4);
  typedef logic [KW_DEFAULT-1:0] keycode_t;

endpackage

// File: rtl/key_fifo.sv
// Show-ahead keycode FIFO: registered head/valid, valid/ready pop, overflow pulse on a
// push that finds the FIFO full with no simultaneous pop.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r, rd_next_s;
  logic [CW-1:0]    count_r, count_after_pop_s, count_next_s;
  logic [WIDTH-1:0] head_r, head_next_s;
  logic             valid_r, overflow_r, full_s, do_pop_s, do_push_s;

  // Next-state of pointers, occupancy and the show-ahead head value.
  always_comb begin
    full_s            = (count_r == FULL_CNT);
    do_pop_s          = valid_r && pop_ready;
    do_push_s         = push && (!full_s || do_pop_s);
    rd_next_s         = do_pop_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
    count_after_pop_s = do_pop_s ? count_r - CW'(1) : count_r;
    count_next_s      = do_push_s ? count_after_pop_s + CW'(1) : count_after_pop_s;
    // A push into an otherwise empty FIFO bypasses storage onto the head register.
    if (count_next_s == '0) begin
      head_next_s = '0;
    end else if (count_after_pop_s == '0) begin
      head_next_s = push_data;
    end else begin
      head_next_s = mem_r[rd_next_s];
    end
  end

  // Storage, pointers and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      head_r     <= '0;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r   <= rd_next_s;
      count_r    <= count_next_s;
      head_r     <= head_next_s;
      valid_r    <= (count_next_s != '0);
      overflow_r <= push && full_s && !do_pop_s;
    end
  end

  assign head     = head_r;
  assign valid    = valid_r;
  assign overflow = overflow_r;

endmodule

// File: rtl/keypad_scan_fifo.sv
// ROWS x COLS keypad scanner with debounced press/release FSM feeding a keycode FIFO.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan_fifo
  import keypad_pkg::*;
#(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int SCAN_DIV      = 480,
  parameter int DB_CYCLES     = 600,
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_DELAY  = 3000000,
  parameter int REPEAT_PERIOD = 600000,
  localparam int KW = kw(ROWS, COLS)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [COLS-1:0] col_i,
  output logic [ROWS-1:0] row_o,
  output logic [KW-1:0]   key_o,
  output logic            key_valid_o,
  input  logic            key_ready_i,
  output logic            held_o,
  output logic            overflow_o
);
  localparam int RW   = $clog2(ROWS);
  localparam int CIW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ONW  = $clog2(COLS + 1);
  localparam int DIVW = $clog2(SCAN_DIV);
  localparam int DBW  = $clog2(DB_CYCLES + 1);

  logic [1:0]      rst_sync_r;
  logic            rst_int_s;
  logic [COLS-1:0] col_meta_r, col_sync_r;
  scan_state_t     state_r;
  logic [ROWS-1:0] row_r;
  logic [RW-1:0]   row_idx_r, row_nxt_s;
  logic [CIW-1:0]  col_idx_r, hit_col_s;
  logic [ONW-1:0]  ones_s;
  logic            one_hot_s, col_on_s;
  logic [DIVW-1:0] div_r;
  logic [DBW-1:0]  db_cnt_r;
  logic            held_r, push_r;
  logic [KW-1:0]   push_code_r, code_s;

`ifdef KEYPAD_REPEAT_EN
  localparam int RPW = $clog2(((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  localparam logic [RPW-1:0] REP_FIRST = RPW'(REPEAT_DELAY - 1);
  localparam logic [RPW-1:0] REP_NEXT  = RPW'(REPEAT_PERIOD - 1);
  logic [RPW-1:0] rep_cnt_r;
  logic           rep_first_r;
`endif

  // Reset asserts asynchronously and is released two clocks after rstn rises.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rst_sync_r <= 2'b00;
    else       rst_sync_r <= {rst_sync_r[0], 1'b1};
  end
  assign rst_int_s = rst_sync_r[1];

  // Two-flop synchroniser for the raw column lines.
  always_ff @(posedge clk or negedge rst_int_s) begin
    if (!rst_int_s) begin
      col_meta_r <= '0;
      col_sync_r <= '0;
    end else begin
      col_meta_r <= col_i;
      col_sync_r <= col_meta_r;
    end
  end

  // Column population count, lone-column index, next row and current keycode.
  always_comb begin
    ones_s    = '0;
    hit_col_s = '0;
    for (int c = 0; c < COLS; c++) begin
      ones_s = ones_s + ONW'(col_sync_r[c]);
      if (col_sync_r[c]) hit_col_s = CIW'(c);
      else               hit_col_s = hit_col_s;
    end
    one_hot_s = (ones_s == ONW'(1));
    col_on_s  = col_sync_r[col_idx_r];
    if (row_idx_r == RW'(ROWS - 1)) row_nxt_s = '0;
    else                            row_nxt_s = row_idx_r + RW'(1);
    code_s = KW'(row_idx_r * COLS + col_idx_r);
  end

  // Scan / debounce / hold FSM.
  always_ff @(posedge clk or negedge rst_int_s) begin
    if (!rst_int_s) begin
      state_r     <= SCAN;
      row_r       <= ROWS'(1);
      row_idx_r   <= '0;
      col_idx_r   <= '0;
      div_r       <= '0;
      db_cnt_r    <= '0;
      held_r      <= 1'b0;
      push_r      <= 1'b0;
      push_code_r <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_r   <= '0;
      rep_first_r <= 1'b1;
`endif
    end else begin
      push_r <= 1'b0;
      case (state_r)
        SCAN: begin
          if (div_r == DIVW'(SCAN_DIV - 1)) begin
            div_r <= '0;
            // Ghosts and chords (zero or several columns) are skipped.
            if (one_hot_s) begin
              col_idx_r <= hit_col_s;
              db_cnt_r  <= '0;
              state_r   <= DB_PRESS;
            end else begin
              row_idx_r <= row_nxt_s;
              row_r     <= ROWS'(1) << row_nxt_s;
            end
          end else begin
            div_r <= div_r + DIVW'(1);
          end
        end
        DB_PRESS: begin
          if (!col_on_s) begin
            db_cnt_r <= '0;
            state_r  <= SCAN;
          end else if (db_cnt_r == DBW'(DB_CYCLES - 1)) begin
            db_cnt_r    <= '0;
            push_r      <= 1'b1;
            push_code_r <= code_s;
            held_r      <= 1'b1;
            state_r     <= HELD;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_r   <= '0;
            rep_first_r <= 1'b1;
`endif
          end else begin
            db_cnt_r <= db_cnt_r + DBW'(1);
          end
        end
        HELD: begin
          if (!col_on_s) begin
            db_cnt_r <= '0;
            state_r  <= DB_RELEASE;
          end else begin
`ifdef KEYPAD_REPEAT_EN
            if (rep_cnt_r == (rep_first_r ? REP_FIRST : REP_NEXT)) begin
              rep_cnt_r   <= '0;
              rep_first_r <= 1'b0;
              push_r      <= 1'b1;
              push_code_r <= code_s;
            end else begin
              rep_cnt_r <= rep_cnt_r + RPW'(1);
            end
`else
            state_r <= HELD;
`endif
          end
        end
        DB_RELEASE: begin
          if (col_on_s) begin
            db_cnt_r <= '0;
            state_r  <= HELD;
          end else if (db_cnt_r == DBW'(DB_CYCLES - 1)) begin
            db_cnt_r  <= '0;
            held_r    <= 1'b0;
            div_r     <= '0;
            row_idx_r <= row_nxt_s;
            row_r     <= ROWS'(1) << row_nxt_s;
            state_r   <= SCAN;
          end else begin
            db_cnt_r <= db_cnt_r + DBW'(1);
          end
        end
        default: state_r <= SCAN;
      endcase
    end
  end

  key_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(KW)) u_fifo (
    .clk       (clk),
    .rstn      (rst_int_s),
    .push      (push_r),
    .push_data (push_code_r),
    .pop_ready (key_ready_i),
    .head      (key_o),
    .valid     (key_valid_o),
    .overflow  (overflow_o)
  );

  assign row_o  = row_r;
  assign held_o = held_r;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo (4x4, SCAN_DIV=8, DB_CYCLES=16, FIFO_DEPTH=4).
module tb_keypad_scan_fifo;
  localparam int ROWS = 4, COLS = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] col, row, key;
  logic       key_valid, key_ready, held, overflow;
  logic [15:0] pressed;
  logic [3:0]  kill;

  keypad_scan_fifo #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(8), .DB_CYCLES(16), .FIFO_DEPTH(4),
    .REPEAT_DELAY(50), .REPEAT_PERIOD(20)
  ) dut (
    .clk(clk), .rstn(rstn), .col_i(col), .row_o(row), .key_o(key),
    .key_valid_o(key_valid), .key_ready_i(key_ready), .held_o(held), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its row drive onto its column.
  always_comb begin
    col = 4'b0000;
    for (int r = 0; r < ROWS; r++) if (row[r]) col = col | pressed[r*4 +: 4];
    col = col & ~kill;
  end

  logic [3:0] popped_q[$];
  int ovf_cnt = 0;
  always @(posedge clk) begin
    if (key_valid && key_ready) popped_q.push_back(key);
    if (overflow) ovf_cnt++;
  end

  int n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_held(input logic val, input int budget, input string name);
    int i = 0;
    while (held !== val && i < budget) begin tick(1); i++; end
    check(name, 32'(held), 32'(val));
  endtask

  task automatic wait_row(input logic [3:0] val, input int budget, input string name);
    int i = 0;
    while (row !== val && i < budget) begin tick(1); i++; end
    check(name, 32'(row), 32'(val));
  endtask

  task automatic press_release(input int r, input int c, input int hold);
    pressed[r*4 + c] = 1'b1;
    wait_held(1'b1, 200, "held_rise");
    tick(hold);
    pressed = '0;
    wait_held(1'b0, 100, "held_fall");
  endtask

  function automatic logic [31:0] q_at(input int i);
    return (i < popped_q.size()) ? 32'(popped_q[i]) : 32'hFFFF_FFFF;
  endfunction

  typedef struct { int row; int col; logic [3:0] code; } press_vec_t;
  press_vec_t vecs[4];
  press_vec_t fill[5];
  logic [3:0] drain_exp[4];

  initial begin
    vecs[0] = '{2, 1, 4'd9};
    vecs[1] = '{0, 0, 4'd0};
    vecs[2] = '{3, 3, 4'd15};
    vecs[3] = '{1, 2, 4'd6};
    fill[0] = '{2, 1, 4'd9};
    fill[1] = '{0, 0, 4'd0};
    fill[2] = '{3, 3, 4'd15};
    fill[3] = '{1, 2, 4'd6};
    fill[4] = '{1, 0, 4'd4};
    drain_exp[0] = 4'd0; drain_exp[1] = 4'd15; drain_exp[2] = 4'd6; drain_exp[3] = 4'd12;

    rstn = 1'b0; key_ready = 1'b0; pressed = '0; kill = '0;
    tick(3);
    check("rst_row", 32'(row), 32'd1);
    check("rst_key", 32'(key), 32'd0);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_held", 32'(held), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rstn = 1'b1;
    tick(4);

    // Single clean presses with the consumer always ready.
    key_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      popped_q.delete();
      press_release(vecs[v].row, vecs[v].col, 40);
      check("resume_row", 32'(row), 32'(4'b0001 << ((vecs[v].row + 1) % 4)));
      tick(5);
      check("pop_count", 32'(popped_q.size()), 32'd1);
      check("pop_code", q_at(0), 32'(vecs[v].code));
    end

    // Bouncing contact on row2/col1, then a stable hold: one code 9.
    popped_q.delete();
    pressed[9] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      kill = (i % 5 == 0) ? 4'b0010 : 4'b0000;
      tick(1);
    end
    kill = '0;
    check("bounce_not_held", 32'(held), 32'd0);
    wait_held(1'b1, 200, "bounce_held_rise");
    tick(40);
    pressed = '0;
    wait_held(1'b0, 100, "bounce_held_fall");
    tick(5);
    check("bounce_count", 32'(popped_q.size()), 32'd1);
    check("bounce_code", q_at(0), 32'd9);

    // Two keys on row 1: chord ignored, scan keeps rotating.
    popped_q.delete();
    pressed[4] = 1'b1; pressed[7] = 1'b1;
    tick(100);
    check("chord_no_push", 32'(popped_q.size()), 32'd0);
    check("chord_not_held", 32'(held), 32'd0);
    begin
      logic [3:0] r0;
      r0 = row;
      tick(8);
      check("chord_rotate", 32'(row), 32'({r0[2:0], r0[3]}));
    end
    pressed = '0;

    // Consumer stalled: four codes stored, fifth dropped with one overflow pulse.
    key_ready = 1'b0;
    popped_q.delete();
    ovf_cnt = 0;
    for (int v = 0; v < 5; v++) press_release(fill[v].row, fill[v].col, 20);
    tick(3);
    check("ovf_once", 32'(ovf_cnt), 32'd1);
    check("full_valid", 32'(key_valid), 32'd1);
    check("full_head", 32'(key), 32'd9);

    // Full FIFO, pop on the push cycle: no overflow, new code lands at the tail.
    pressed[12] = 1'b1;
    wait_held(1'b1, 200, "pp_held_rise");
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
    tick(20);
    pressed = '0;
    wait_held(1'b0, 100, "pp_held_fall");
    tick(3);
    check("pp_no_ovf", 32'(ovf_cnt), 32'd1);
    check("pp_pop_count", 32'(popped_q.size()), 32'd1);
    check("pp_pop_code", q_at(0), 32'd9);
    popped_q.delete();
    key_ready = 1'b1;
    tick(10);
    check("drain_count", 32'(popped_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("drain_order", q_at(i), 32'(drain_exp[i]));

    // Reset while debouncing a press discards both the FIFO and the latched key.
    key_ready = 1'b0;
    popped_q.delete();
    press_release(0, 0, 20);
    tick(3);
    check("pre_rst_valid", 32'(key_valid), 32'd1);
    wait_row(4'b0001, 100, "wait_row0");
    pressed[9] = 1'b1;
    wait_row(4'b0100, 100, "wait_row2");
    tick(12);
    check("db_frozen_row", 32'(row), 32'd4);
    check("db_not_held", 32'(held), 32'd0);
    rstn = 1'b0;
    #1;
    check("mid_rst_row", 32'(row), 32'd1);
    check("mid_rst_valid", 32'(key_valid), 32'd0);
    check("mid_rst_held", 32'(held), 32'd0);
    tick(3);
    pressed = '0;
    rstn = 1'b1;
    key_ready = 1'b1;
    tick(100);
    check("post_rst_no_pop", 32'(popped_q.size()), 32'd0);
    check("post_rst_valid", 32'(key_valid), 32'd0);

`ifdef KEYPAD_REPEAT_EN
    // Held 100 cycles: press push plus repeats at 50, 70 and 90.
    popped_q.delete();
    pressed[5] = 1'b1;
    wait_held(1'b1, 200, "rep_held_rise");
    tick(100);
    pressed = '0;
    wait_held(1'b0, 100, "rep_held_fall");
    tick(5);
    check("rep_count", 32'(popped_q.size()), 32'd4);
    check("rep_first", q_at(0), 32'd5);
    check("rep_last", q_at(3), 32'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
